// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle for unified_mem_arbiter: fetch port, data port, shared
// single-port memory command/response, and stall monitoring.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants,
//            responses, the memory command and the stall outputs)
//   master : requester/memory view (the mirror image)
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 12
);
  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  // data port
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  // shared memory
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  // stall monitor
  logic              stall_if;
  logic [15:0]       stall_cnt;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata,
    output stall_if, stall_cnt
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata,
    input  stall_if, stall_cnt
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store data port onto one
// synchronous single-port memory (read data valid one cycle after command).
// Data wins conflicts until it has won MAX_DSTREAK conflicts in a row, then
// fetch is forced through. Grants and the memory command are combinational;
// response strobes come from registered per-port pending flags.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - unified_mem_arbiter_if.slave (fetch/data ports, memory command,
//          mem_rdata, stall_if, stall_cnt)
module unified_mem_arbiter #(
  parameter int ADDR_W      = 12,
  parameter int MAX_DSTREAK = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.slave  bus
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  logic [3:0]        streak;
  logic              if_pend;
  logic              d_pend;
  logic [15:0]       stall_cnt_q;

  logic              if_win;
  logic              if_gnt;
  logic              d_gnt;
  logic              stall;
  logic [ADDR_W-1:0] sel_addr;

  always_comb begin
    if_win   = bus.if_req & (~bus.d_req | (streak == STREAK_MAX));
    if_gnt   = ~rst & if_win;
    d_gnt    = ~rst & bus.d_req & ~if_win;
    stall    = ~rst & bus.if_req & ~if_win;
    sel_addr = d_gnt ? bus.d_addr : bus.if_addr;
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = if_gnt | d_gnt;
  assign bus.mem_we    = d_gnt & bus.d_we;
  assign bus.mem_be    = (d_gnt & bus.d_we) ? bus.d_be : 4'hF;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = bus.d_wdata;

  // Pending flags are also masked by rst so a command issued just before
  // reset asserts never produces a strobe during the reset cycle.
  assign bus.if_rvalid = if_pend & ~bus.if_flush & ~rst;
  assign bus.d_rvalid  = d_pend & ~rst;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

  assign bus.stall_if  = stall;
  assign bus.stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      streak      <= '0;
      if_pend     <= 1'b0;
      d_pend      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if_pend <= if_gnt;
      d_pend  <= d_gnt & ~bus.d_we;
      if (if_gnt) begin
        streak <= '0;
      end else if (d_gnt && bus.if_req && (streak != STREAK_MAX)) begin
        streak <= streak + 4'd1;
      end
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Testbench for unified_mem_arbiter: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic checked every cycle against
// a behavioural model (shadow memory, streak/stall integers).
module tb_unified_mem_arbiter;
  localparam int ADDR_W = 12;
  localparam int MAXD   = 3;
  localparam int WORDS  = 1 << (ADDR_W - 2);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  unified_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_DSTREAK(MAXD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 16) return 32'h1122_3344;
    return 32'hA500_0000 | 32'(i);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memory behaviour: synchronous single port, registered read data.
  logic [31:0] mem [WORDS];
  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = init_word(i);
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_en === 1'b1) begin
        if (bus.mem_we)
          mem[bus.mem_addr[ADDR_W-1:2]] = merge(mem[bus.mem_addr[ADDR_W-1:2]], bus.mem_wdata, bus.mem_be);
        else
          bus.mem_rdata = mem[bus.mem_addr[ADDR_W-1:2]];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic [31:0] shadow [WORDS];
  int          m_streak = 0;
  int          m_stall  = 0;
  bit          m_ipend  = 0;
  bit          m_dpend  = 0;
  bit          m_known  = 0;
  logic [31:0] m_idata, m_ddata;
  bit          e_ig = 0;
  bit          e_dg = 0;

  task automatic model_step();
    bit eig, edg, est, eirv, edrv;
    if (rst) begin
      eig = 0; edg = 0; est = 0; eirv = 0; edrv = 0;
    end else begin
      eig  = bus.if_req && (!bus.d_req || m_streak >= MAXD);
      edg  = bus.d_req && !eig;
      est  = bus.if_req && !eig;
      eirv = m_ipend && !bus.if_flush;
      edrv = m_dpend;
    end
    chk("m.if_gnt",    32'(bus.if_gnt),    32'(eig));
    chk("m.d_gnt",     32'(bus.d_gnt),     32'(edg));
    chk("m.stall_if",  32'(bus.stall_if),  32'(est));
    chk("m.mem_en",    32'(bus.mem_en),    32'(eig || edg));
    chk("m.mem_we",    32'(bus.mem_we),    32'(edg && bus.d_we));
    if (eig || edg) begin
      chk("m.mem_addr", 32'(bus.mem_addr), 32'(edg ? bus.d_addr : bus.if_addr));
      chk("m.mem_be",   32'(bus.mem_be),   32'((edg && bus.d_we) ? bus.d_be : 4'hF));
    end
    if (edg && bus.d_we) chk("m.mem_wdata", bus.mem_wdata, bus.d_wdata);
    chk("m.if_rvalid", 32'(bus.if_rvalid), 32'(eirv));
    chk("m.d_rvalid",  32'(bus.d_rvalid),  32'(edrv));
    if (eirv) chk("m.if_rdata", bus.if_rdata, m_idata);
    if (edrv) chk("m.d_rdata",  bus.d_rdata,  m_ddata);
    if (m_known) chk("m.stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
    if (rst) begin
      m_streak = 0; m_stall = 0; m_ipend = 0; m_dpend = 0; m_known = 1;
    end else begin
      if (eig) m_streak = 0;
      else if (edg && bus.if_req && m_streak < MAXD) m_streak++;
      if (est && m_stall < 65535) m_stall++;
      m_ipend = eig;
      if (eig) m_idata = shadow[bus.if_addr[ADDR_W-1:2]];
      m_dpend = edg && !bus.d_we;
      if (m_dpend) m_ddata = shadow[bus.d_addr[ADDR_W-1:2]];
      if (edg && bus.d_we)
        shadow[bus.d_addr[ADDR_W-1:2]] = merge(shadow[bus.d_addr[ADDR_W-1:2]], bus.d_wdata, bus.d_be);
    end
    e_ig = eig;
    e_dg = edg;
  endtask

  task automatic set_in(input logic r, input logic ir, input logic [ADDR_W-1:0] ia, input logic fl,
                        input logic dr, input logic dw, input logic [3:0] be,
                        input logic [ADDR_W-1:0] da, input logic [31:0] wd);
    rst = r;
    bus.if_req = ir; bus.if_addr = ia; bus.if_flush = fl;
    bus.d_req = dr; bus.d_we = dw; bus.d_be = be; bus.d_addr = da; bus.d_wdata = wd;
  endtask

  task automatic idle(input logic r);
    set_in(r, 1'b0, '0, 1'b0, 1'b0, 1'b0, 4'hF, '0, '0);
  endtask

  task automatic finish_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic              rst;
    logic              ir;
    logic [ADDR_W-1:0] ia;
    logic              fl;
    logic              dr;
    logic              dw;
    logic [3:0]        be;
    logic [ADDR_W-1:0] da;
    logic [31:0]       wd;
    logic              eig;
    logic              edg;
    logic              est;
    logic              eirv;
    logic              edrv;
    logic [31:0]       erd;
    logic [15:0]       esc;
  } vec_t;

  vec_t vecs [11];
  logic [7:0] pat;
  logic r_rst, r_ir, r_fl, r_dr, r_dw;
  logic [3:0] r_be;
  logic [ADDR_W-1:0] r_ia, r_da;
  logic [31:0] r_wd;

  initial begin
    for (int i = 0; i < WORDS; i++) shadow[i] = init_word(i);
    //            rst ir ia       fl dr dw be    da       wd            eig edg est irv drv erd           esc
    vecs[0]  = '{1, 1, 12'h000, 0, 1, 0, 4'hF, 12'h000, 32'h0,         0, 0, 0, 0, 0, 32'h0,         16'd0};
    vecs[1]  = '{0, 1, 12'h000, 0, 0, 0, 4'hF, 12'h000, 32'h0,         1, 0, 0, 0, 0, 32'h0,         16'd0};
    vecs[2]  = '{0, 1, 12'h004, 0, 0, 0, 4'hF, 12'h000, 32'h0,         1, 0, 0, 1, 0, 32'hA500_0000, 16'd0};
    vecs[3]  = '{0, 1, 12'h008, 0, 0, 0, 4'hF, 12'h000, 32'h0,         1, 0, 0, 1, 0, 32'hA500_0001, 16'd0};
    vecs[4]  = '{0, 0, 12'h000, 0, 0, 0, 4'hF, 12'h000, 32'h0,         0, 0, 0, 1, 0, 32'hA500_0002, 16'd0};
    vecs[5]  = '{0, 1, 12'h010, 0, 1, 0, 4'hF, 12'h100, 32'h0,         0, 1, 1, 0, 0, 32'h0,         16'd0};
    vecs[6]  = '{0, 1, 12'h010, 0, 0, 0, 4'hF, 12'h000, 32'h0,         1, 0, 0, 0, 1, 32'hA500_0040, 16'd1};
    vecs[7]  = '{0, 0, 12'h000, 0, 0, 0, 4'hF, 12'h000, 32'h0,         0, 0, 0, 1, 0, 32'hA500_0004, 16'd1};
    vecs[8]  = '{0, 0, 12'h000, 0, 1, 1, 4'h3, 12'h040, 32'hAABB_CCDD, 0, 1, 0, 0, 0, 32'h0,         16'd1};
    vecs[9]  = '{0, 0, 12'h000, 0, 1, 0, 4'hF, 12'h040, 32'h0,         0, 1, 0, 0, 0, 32'h0,         16'd1};
    vecs[10] = '{0, 0, 12'h000, 0, 0, 0, 4'hF, 12'h000, 32'h0,         0, 0, 0, 0, 1, 32'h1122_CCDD, 16'd1};

    idle(1'b1);
    @(posedge clk); #1;
    idle(1'b1); #5; finish_cycle();
    idle(1'b1); #5; finish_cycle();

    // Directed vectors: fetch stream, conflict, partial store then load.
    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].rst, vecs[i].ir, vecs[i].ia, vecs[i].fl, vecs[i].dr, vecs[i].dw,
             vecs[i].be, vecs[i].da, vecs[i].wd);
      #5;
      chk($sformatf("v%0d.if_gnt", i),    32'(bus.if_gnt),    32'(vecs[i].eig));
      chk($sformatf("v%0d.d_gnt", i),     32'(bus.d_gnt),     32'(vecs[i].edg));
      chk($sformatf("v%0d.stall_if", i),  32'(bus.stall_if),  32'(vecs[i].est));
      chk($sformatf("v%0d.if_rvalid", i), 32'(bus.if_rvalid), 32'(vecs[i].eirv));
      chk($sformatf("v%0d.d_rvalid", i),  32'(bus.d_rvalid),  32'(vecs[i].edrv));
      if (vecs[i].eirv) chk($sformatf("v%0d.if_rdata", i), bus.if_rdata, vecs[i].erd);
      if (vecs[i].edrv) chk($sformatf("v%0d.d_rdata", i),  bus.d_rdata,  vecs[i].erd);
      chk($sformatf("v%0d.stall_cnt", i), 32'(bus.stall_cnt), 32'(vecs[i].esc));
      finish_cycle();
    end

    // Continuous conflict: D,D,D,I,D,D,D,I and six stalled cycles.
    pat = 8'b1000_1000;
    idle(1'b1); #5; finish_cycle();
    for (int k = 0; k < 8; k++) begin
      set_in(1'b0, 1'b1, 12'h010, 1'b0, 1'b1, 1'b0, 4'hF, 12'h100, 32'h0);
      #5;
      chk($sformatf("streak%0d.if_gnt", k), 32'(bus.if_gnt), 32'(pat[k]));
      chk($sformatf("streak%0d.d_gnt", k),  32'(bus.d_gnt),  32'(!pat[k]));
      finish_cycle();
    end
    idle(1'b0); #5;
    chk("streak.stall_cnt", 32'(bus.stall_cnt), 32'd6);
    finish_cycle();

    // Flushed fetch response is dropped, not delayed.
    idle(1'b1); #5; finish_cycle();
    set_in(1'b0, 1'b1, 12'h020, 1'b0, 1'b0, 1'b0, 4'hF, '0, '0); #5;
    chk("flush.if_gnt", 32'(bus.if_gnt), 32'd1);
    finish_cycle();
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 4'hF, '0, '0); #5;
    chk("flush.if_rvalid", 32'(bus.if_rvalid), 32'd0);
    finish_cycle();
    idle(1'b0); #5;
    chk("flush.late_rvalid", 32'(bus.if_rvalid), 32'd0);
    finish_cycle();

    // Reset right after a load grant: no strobe, counters cleared.
    idle(1'b1); #5; finish_cycle();
    for (int k = 0; k < 2; k++) begin
      set_in(1'b0, 1'b1, 12'h030, 1'b0, 1'b1, 1'b0, 4'hF, 12'h0C0, 32'h0); #5;
      chk($sformatf("rstld%0d.d_gnt", k), 32'(bus.d_gnt), 32'd1);
      finish_cycle();
    end
    set_in(1'b1, 1'b1, 12'h030, 1'b0, 1'b1, 1'b0, 4'hF, 12'h0C0, 32'h0); #5;
    chk("rstld.d_rvalid", 32'(bus.d_rvalid), 32'd0);
    chk("rstld.if_gnt",   32'(bus.if_gnt),   32'd0);
    chk("rstld.d_gnt",    32'(bus.d_gnt),    32'd0);
    chk("rstld.stall_if", 32'(bus.stall_if), 32'd0);
    chk("rstld.mem_en",   32'(bus.mem_en),   32'd0);
    finish_cycle();
    pat = 8'b0000_1000;
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b1, 12'h030, 1'b0, 1'b1, 1'b0, 4'hF, 12'h0C0, 32'h0); #5;
      if (k == 0) chk("rstld.stall_cnt0", 32'(bus.stall_cnt), 32'd0);
      chk($sformatf("rstld_after%0d.if_gnt", k), 32'(bus.if_gnt), 32'(pat[k]));
      finish_cycle();
    end
    idle(1'b0); #5;
    chk("rstld.stall_cnt3", 32'(bus.stall_cnt), 32'd3);
    finish_cycle();

    // Random traffic; requests held until the model says granted.
    r_ir = 0; r_dr = 0; r_ia = '0; r_da = '0; r_dw = 0; r_be = 4'hF; r_wd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!r_ir || e_ig) begin
        r_ir = ($urandom_range(0, 9) < 6);
        r_ia = ADDR_W'($urandom_range(0, 63) * 4);
      end
      if (!r_dr || e_dg) begin
        r_dr = ($urandom_range(0, 9) < 6);
        r_dw = ($urandom_range(0, 2) == 0);
        r_be = 4'($urandom_range(1, 15));
        r_da = ADDR_W'($urandom_range(0, 63) * 4);
        r_wd = $urandom;
      end
      r_rst = ($urandom_range(0, 63) == 0);
      r_fl  = ($urandom_range(0, 5) == 0);
      set_in(r_rst, r_ir, r_ia, r_fl, r_dr, r_dw, r_be, r_da, r_wd);
      #5;
      finish_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning byte-address width of the shared memory.
REQ-002 The block SHALL have parameter MAX_DSTREAK, default 3, meaning consecutive conflict wins allowed to the data port before the fetch port is forced through (range 1-15).
REQ-003 Clock  in  1  single clock, all state updates on rising edge.
REQ-004 Reset  in  1  synchronous, active-high.
REQ-005 if_req  in  1  fetch request, held with if_addr until granted.
REQ-006 if_addr  in  ADDR_W  fetch byte address (word-aligned).
REQ-007 if_flush  in  1  discard fetch response due next cycle (taken branch).
REQ-008 if_gnt  out  1  fetch request issued to memory this cycle.
REQ-009 if_rvalid  out  1  fetch read data valid.
REQ-010 if_rdata  out  32  fetch read data.
REQ-011 d_req  in  1  data request, held with d_we/d_be/d_addr/d_wdata until granted.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_be  in  4  store byte enables.
REQ-014 d_addr  in  ADDR_W  data byte address.
REQ-015 d_wdata  in  32  store data.
REQ-016 d_gnt  out  1  data request issued this cycle.
REQ-017 d_rvalid  out  1  load data valid (never asserted for stores).
REQ-018 d_rdata  out  32  load data.
REQ-019 mem_en, mem_we (1), mem_be (4), mem_addr (ADDR_W), mem_wdata (32)  out  synchronous single-port memory command, sampled by memory at rising edge.
REQ-020 mem_rdata  in  32  memory read data, valid the cycle after a read command.
REQ-021 stall_if  out  1  if_req & ~if_gnt.
REQ-022 stall_cnt  out  16  saturating count of cycles with stall_if high.

Function
REQ-023 The block SHALL issue at most one memory command per cycle; if_gnt and d_gnt SHALL never both be 1.
REQ-024 if_gnt/d_gnt and mem_* SHALL be combinational from current requests and registered arbitration state; requesters may change request fields at the edge following a grant.
REQ-025 With only one request pending, that port SHALL be granted in the same cycle.
REQ-026 On conflict (both requests), the data port SHALL win unless streak counter = MAX_DSTREAK, in which case the fetch port SHALL win.
REQ-027 Streak counter: +1 on each conflict won by data; cleared on any fetch grant; saturates at MAX_DSTREAK.
REQ-028 Fetch grant drives mem_we=0, mem_be=4'hF, mem_addr=if_addr; data grant drives mem_we=d_we, mem_be=d_be (4'hF for loads), mem_addr=d_addr, mem_wdata=d_wdata; no grant drives mem_en=0, mem_we=0.
REQ-029 Response routing SHALL be registered: if_rvalid=1 the cycle after if_gnt unless if_flush was 1 in the cycle if_rvalid would assert; d_rvalid=1 the cycle after d_gnt with d_we=0.
REQ-030 if_rdata and d_rdata SHALL both equal mem_rdata combinationally; only the rvalid strobes are port-specific.
REQ-031 Back-to-back grants to the same port SHALL be supported, one per cycle (full throughput).
REQ-032 stall_cnt SHALL increment when stall_if=1 and hold at 16'hFFFF.

Reset
REQ-033 While Reset=1: if_gnt=0, d_gnt=0, mem_en=0, mem_we=0, stall_if=0 regardless of requests.
REQ-034 At the edge with Reset=1: if_rvalid=0, d_rvalid=0, streak counter=0, stall_cnt=0; a command issued in the cycle before Reset SHALL produce no rvalid.
REQ-035 The first cycle after Reset deasserts SHALL arbitrate normally with data priority.

Verification
REQ-036 if_req=1, if_addr=0x000,0x004,0x008 over three cycles, d_req=0 -> if_gnt=1 each cycle, if_rvalid=1 on cycles 2-4 with mem contents of each address, stall_cnt=0.
REQ-037 d_req=1 load 0x100 and if_req=1 0x010 in same cycle -> d_gnt=1, if_gnt=0, stall_if=1; next cycle if_gnt=1, d_rvalid=1; stall_cnt=1.
REQ-038 Both ports requesting continuously, MAX_DSTREAK=3 -> grant pattern D,D,D,I,D,D,D,I; stall_cnt=6 after 8 cycles.
REQ-039 Store d_addr=0x040, d_be=4'b0011, d_wdata=0xAABBCCDD to a word holding 0x11223344, then load 0x040 -> d_rvalid=0 after store, load returns 0x1122CCDD.
REQ-040 if_gnt for 0x020 then if_flush=1 the following cycle -> if_rvalid=0; Reset=1 one cycle after a d_gnt load -> d_rvalid=0, stall_cnt=0, streak=0.
